// File: rtl/cv32e40p_ldm_alarm_handler.sv
// rtl/cv32e40p_ldm_alarm_handler.sv - alarm filter, interrupt and fetch-halt escalation for the loop/deadlock monitor
//
// Purpose:
//   Debounces the raw alarm from the loop/deadlock detector. Once the alarm has
//   been high for FILTER_CYCLES consecutive samples, the handler raises an
//   interrupt. It then waits up to ACK_TIMEOUT cycles for an acknowledge. If no
//   acknowledge arrives in that window, it requests a fetch halt that stays set
//   until clear_i or rst.
//
// Parameters:
//   FILTER_CYCLES  consecutive alarm_i-high samples needed to accept an alarm (>=1)
//   ACK_TIMEOUT    maximum number of cycles irq_o stays high before escalation (>=1)
//   CNT_WIDTH      width of the saturating accepted-alarm counter
//
// Ports:
//   clk          core clock, rising edge
//   rst          asynchronous active-high reset
//   alarm_i      raw alarm from the detector
//   pc_id_i      PC of the instruction in ID, captured when an alarm is accepted
//   irq_ack_i    interrupt acknowledge
//   clear_i      software/debug clear; forces IDLE, has priority over all inputs
//   irq_o        registered alarm interrupt request (high only in IRQ)
//   halt_o       registered fetch-halt request (high only in HALT)
//   alarm_cnt_o  saturating count of accepted alarms
//   alarm_pc_o   PC captured at the last accepted alarm
//
// Configuration:
//   CV32E40P_LDM_ALARM_PC_LOG_EN  when defined, builds the PC capture register;
//                                 when undefined, alarm_pc_o is tied to zero.

module cv32e40p_ldm_alarm_handler #(
    parameter int FILTER_CYCLES = 2,
    parameter int ACK_TIMEOUT   = 64,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alarm_i,
    input  logic [31:0]          pc_id_i,
    input  logic                 irq_ack_i,
    input  logic                 clear_i,
    output logic                 irq_o,
    output logic                 halt_o,
    output logic [CNT_WIDTH-1:0] alarm_cnt_o,
    output logic [31:0]          alarm_pc_o
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LOAD  = TW'(ACK_TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FILTER = 2'd1;
    localparam logic [1:0] S_IRQ    = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [FW-1:0]        filt_q, filt_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 accept;
    logic                 irq_q, halt_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        tmo_d   = tmo_q;
        accept  = 1'b0;

        if (clear_i) begin
            state_d = S_IDLE;
            filt_d  = '0;
            tmo_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (alarm_i) begin
                        // With a single-sample filter the first high sample is already accepted.
                        if (FILTER_CYCLES == 1) begin
                            accept = 1'b1;
                        end else begin
                            state_d = S_FILTER;
                            filt_d  = FW'(1);
                        end
                    end
                end
                S_FILTER: begin
                    if (!alarm_i) begin
                        state_d = S_IDLE;
                        filt_d  = '0;
                    end else if (filt_q == FILT_LAST) begin
                        accept = 1'b1;
                    end else begin
                        filt_d = filt_q + FW'(1);
                    end
                end
                S_IRQ: begin
                    // Acknowledge wins over an expiring timeout.
                    if (irq_ack_i) begin
                        state_d = S_IDLE;
                        tmo_d   = '0;
                    end else if (tmo_q == '0) begin
                        state_d = S_HALT;
                    end else begin
                        tmo_d = tmo_q - TW'(1);
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_IDLE;
                    filt_d  = '0;
                    tmo_d   = '0;
                end
            endcase

            if (accept) begin
                state_d = S_IRQ;
                filt_d  = '0;
                tmo_d   = TMO_LOAD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            filt_q  <= '0;
            tmo_q   <= '0;
            irq_q   <= 1'b0;
            halt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            tmo_q   <= tmo_d;
            irq_q   <= (state_d == S_IRQ);
            halt_q  <= (state_d == S_HALT);
            if (accept && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign irq_o       = irq_q;
    assign halt_o      = halt_q;
    assign alarm_cnt_o = cnt_q;

`ifdef CV32E40P_LDM_ALARM_PC_LOG_EN
    logic [31:0] pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= 32'h0;
        end else if (accept) begin
            pc_q <= pc_id_i;
        end
    end

    assign alarm_pc_o = pc_q;
`else
    logic unused_pc;

    assign unused_pc  = ^pc_id_i;
    assign alarm_pc_o = 32'h0;
`endif

endmodule
